// File: rtl/cont9_pkg.sv
// Shared types and constants for the decade counter digit.
// Segment codes are active-high, bit order {g,f,e,d,c,b,a}.
package cont9_pkg;

  localparam int SEG_W   = 7;
  localparam int DIGIT_W = 4;

  typedef logic [SEG_W-1:0]   seg_t;
  typedef logic [DIGIT_W-1:0] digit_t;

  localparam seg_t SEG_0     = 7'b0111111;
  localparam seg_t SEG_1     = 7'b0000110;
  localparam seg_t SEG_2     = 7'b1011011;
  localparam seg_t SEG_3     = 7'b1001111;
  localparam seg_t SEG_4     = 7'b1100110;
  localparam seg_t SEG_5     = 7'b1101101;
  localparam seg_t SEG_6     = 7'b1111101;
  localparam seg_t SEG_7     = 7'b0000111;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1101111;
  localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/cont9_digit_if.sv
// Counter digit bus: tick/control inputs and count/flag/segment outputs.
// master = driver of controls (upstream), slave = the counter digit.
interface cont9_digit_if;
  import cont9_pkg::*;

  logic   tick_in;
  logic   en;
  logic   up_dn;
  logic   load;
  digit_t load_val;
  digit_t count;
  logic   carry;
  logic   borrow;
  seg_t   seg;

  modport master (
    output tick_in, en, up_dn, load, load_val,
    input  count, carry, borrow, seg
  );

  modport slave (
    input  tick_in, en, up_dn, load, load_val,
    output count, carry, borrow, seg
  );

endinterface

// File: rtl/seg7_dec.sv
// BCD to 7-segment decoder, purely combinational; codes >9 blank.
// Ports: digit[3:0] in, seg[6:0] {g,f,e,d,c,b,a} out.
module seg7_dec
  import cont9_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  digit_t digit,
  output seg_t   seg
);

  seg_t raw;

  always_comb begin
    raw = SEG_BLANK;
    case (digit)
      4'd0:    raw = SEG_0;
      4'd1:    raw = SEG_1;
      4'd2:    raw = SEG_2;
      4'd3:    raw = SEG_3;
      4'd4:    raw = SEG_4;
      4'd5:    raw = SEG_5;
      4'd6:    raw = SEG_6;
      4'd7:    raw = SEG_7;
      4'd8:    raw = SEG_8;
      4'd9:    raw = SEG_9;
      default: raw = SEG_BLANK;
    endcase
  end

  assign seg = SEG_ACTIVE_LOW ? ~raw : raw;

endmodule

// File: rtl/cont9_digit.sv
// Decade counter digit stepped by rising edges of the prescaler tick.
// Ports: clk, rst (async active-low), bus (cont9_digit_if.slave).
// Option: CONT9_SYNC_EN adds a 2-flop synchronizer on tick_in.
module cont9_digit
  import cont9_pkg::*;
#(
  parameter int unsigned MAX            = 9,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input logic         clk,
  input logic         rst,
  cont9_digit_if.slave bus
);

  localparam digit_t MAX_D = DIGIT_W'(MAX);

  logic   tick_src;
  logic   tick_q;
  logic   tick_q_d;
  logic   step;
  digit_t count_q;
  logic   carry_q;
  logic   borrow_q;

`ifdef CONT9_SYNC_EN
  logic sync1;
  logic sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= bus.tick_in;
      sync2 <= sync1;
    end
  end

  assign tick_src = sync2;
`else
  // tick_in is already clk-synchronous when fed by the prescaler.
  assign tick_src = bus.tick_in;
`endif

  // A tick already high at reset release reads as a rising edge,
  // because tick_q_d resets to 0.
  assign step = tick_q & ~tick_q_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q   <= 1'b0;
      tick_q_d <= 1'b0;
      count_q  <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      tick_q   <= tick_src;
      tick_q_d <= tick_q;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      if (bus.load) begin
        // Out-of-range loads clamp to 0; a coincident step is dropped.
        count_q <= (bus.load_val > MAX_D) ? '0 : bus.load_val;
      end else if (step && bus.en) begin
        if (bus.up_dn) begin
          if (count_q == MAX_D) begin
            count_q <= '0;
            carry_q <= 1'b1;
          end else begin
            count_q <= count_q + 4'd1;
          end
        end else begin
          if (count_q == '0) begin
            count_q  <= MAX_D;
            borrow_q <= 1'b1;
          end else begin
            count_q <= count_q - 4'd1;
          end
        end
      end
    end
  end

  assign bus.count  = count_q;
  assign bus.carry  = carry_q;
  assign bus.borrow = borrow_q;

  seg7_dec #(
    .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_dec (
    .digit (count_q),
    .seg   (bus.seg)
  );

endmodule

// File: tb/tb_cont9_digit.sv
// Directed self-checking bench for cont9_digit (MAX=9, active-low segs).
// Expected values are hand-computed constants per step.
module tb_cont9_digit;
  import cont9_pkg::*;

`ifdef CONT9_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   ntest = 0;
  int   nfail = 0;

  cont9_digit_if bus ();

  cont9_digit #(
    .MAX            (9),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise tick_in at a negedge, return #1 after the edge that
  // should update count, then drop tick_in and settle.
  task automatic rise_and_check(input logic [3:0] exp_cnt,
                                input logic exp_c, input logic exp_b);
    @(negedge clk);
    bus.tick_in = 1'b1;
    repeat (LAT) @(posedge clk);
    #1;
    chk("rise_count", 8'(bus.count), 8'(exp_cnt));
    chk("rise_carry", 8'(bus.carry), 8'(exp_c));
    chk("rise_borrow", 8'(bus.borrow), 8'(exp_b));
    @(posedge clk);
    #1;
    chk("flag_clear", 8'({bus.carry, bus.borrow}), 8'd0);
    @(negedge clk);
    bus.tick_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bus.tick_in  = 1'b0;
    bus.en       = 1'b1;
    bus.up_dn    = 1'b1;
    bus.load     = 1'b0;
    bus.load_val = 4'd0;

    // Reset held with tick_in toggling
    repeat (6) begin
      @(negedge clk);
      bus.tick_in = ~bus.tick_in;
    end
    chk("rst_count", 8'(bus.count), 8'd0);
    chk("rst_seg", 8'(bus.seg), 8'h40);
    chk("rst_carry", 8'(bus.carry), 8'd0);
    chk("rst_borrow", 8'(bus.borrow), 8'd0);

    @(negedge clk);
    bus.tick_in = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // First rise: count must not move one edge early
    bus.tick_in = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1;
    chk("lat_early", 8'(bus.count), 8'd0);
    @(posedge clk);
    #1;
    chk("lat_count", 8'(bus.count), 8'd1);
    @(negedge clk);
    bus.tick_in = 1'b0;
    repeat (3) @(negedge clk);

    // Up count 2..9 then wrap to 0 with carry
    for (int i = 2; i <= 9; i++)
      rise_and_check(4'(i), 1'b0, 1'b0);
    rise_and_check(4'd0, 1'b1, 1'b0);

    // Down wrap 0 -> 9 with borrow, then 8
    bus.up_dn = 1'b0;
    rise_and_check(4'd9, 1'b0, 1'b1);
    rise_and_check(4'd8, 1'b0, 1'b0);

    // Load 12 coincident with a step: clamps to 0, step dropped
    @(negedge clk);
    bus.tick_in = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    bus.load     = 1'b1;
    bus.load_val = 4'd12;
    @(posedge clk);
    #1;
    chk("load12_count", 8'(bus.count), 8'd0);
    chk("load12_flags", 8'({bus.carry, bus.borrow}), 8'd0);
    @(negedge clk);
    bus.load    = 1'b0;
    bus.tick_in = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    chk("load12_drop", 8'(bus.count), 8'd0);
    chk("load12_flg2", 8'({bus.carry, bus.borrow}), 8'd0);

    // Load 5
    bus.load     = 1'b1;
    bus.load_val = 4'd5;
    @(negedge clk);
    bus.load = 1'b0;
    chk("load5_count", 8'(bus.count), 8'd5);
    chk("load5_seg", 8'(bus.seg), 8'h12);

    // Enable low: three edges lost
    bus.en    = 1'b0;
    bus.up_dn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      bus.tick_in = 1'b1;
      repeat (3) @(negedge clk);
      bus.tick_in = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (LAT) @(negedge clk);
    chk("en_hold", 8'(bus.count), 8'd5);
    bus.en = 1'b1;
    repeat (3) @(negedge clk);
    chk("en_not_defer", 8'(bus.count), 8'd5);

    // tick_in held high 100 clocks: exactly one increment
    bus.tick_in = 1'b1;
    repeat (100) @(negedge clk);
    chk("held_high", 8'(bus.count), 8'd6);
    chk("held_seg", 8'(bus.seg), 8'h02);
    bus.tick_in = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    chk("held_after", 8'(bus.count), 8'd6);

    // Async reset between edges at count 7
    bus.load     = 1'b1;
    bus.load_val = 4'd7;
    @(negedge clk);
    bus.load = 1'b0;
    chk("pre_rst7", 8'(bus.count), 8'd7);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_count", 8'(bus.count), 8'd0);
    chk("async_seg", 8'(bus.seg), 8'h40);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
